pwm_duty_sequencer: RTL
=======================

// Module: pwm_duty_sequencer
// PURPOSE
//  Sequences the duty-cycle setting of a downstream PWM generator. Steps duty up/down by a
//  programmable increment, holds each level for a programmable dwell, and hands every new level
//  to the PWM core over a valid/ready handshake. The PWM core accepts a level at its period boundary.
//  Sits between the control/config logic and the PWM core.
// PARAMETERS
//  DUTY_W    8    width of duty code
//  MAX_DUTY  255  full-scale (100%) duty code; must be < 2**DUTY_W
//  DWELL_W   32   width of dwell counter and cfg_dwell
// PORTS
//  clk         in   1        rising-edge clock
//  rst         in   1        asynchronous, active-high reset
//  enable      in   1        run request (level)
//  cfg_mode    in   2        0=triangle, 1=sawtooth, 2=single ramp-up, 3=reserved (acts as 0)
//  cfg_step    in   DUTY_W   duty increment per step (0 treated as 1)
//  cfg_dwell   in   DWELL_W  clocks between accept and next issue (0 treated as 1)
//  duty        out  DUTY_W   duty code presented to PWM core
//  duty_valid  out  1        duty is a new level to be accepted
//  duty_ready  in   1        PWM core accepts duty (handshake = valid & ready at clk edge)
//  dir         out  1        0=ramping up, 1=ramping down
//  busy        out  1        high in ISSUE or DWELL
//  cycle_done  out  1        one-clock pulse at sequence wrap/finish
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, duty=0, duty_valid=0, dir=0, busy=0, cycle_done=0, dwell cnt=0.
//  States: IDLE, ISSUE, DWELL, DONE. busy = (ISSUE|DWELL). duty_valid = (state==ISSUE).
//  IDLE: if enable=1, latch cfg_mode/step/dwell (zero->1) -> ISSUE; duty_valid high 1 clk after the edge.
//   Cfg is sampled only here; changes while running are ignored.
//  ISSUE: duty_valid=1, duty stable until handshake. On handshake -> DWELL, cnt=dwell-1;
//   valid is low for exactly dwell cycles, then reasserts with next level.
//   valid never drops without a handshake, even if enable falls.
//  DWELL: if enable=0 -> IDLE (duty/dir retained). Else, if cnt!=0, decrement.
//   When cnt==0: compute next duty, pulse cycle_done if needed, -> ISSUE (or DONE).
//  Next-level arithmetic (sum in DUTY_W+1 bits, no overflow):
//   up,   triangle : d'=min(d+step,MAX); if d'==MAX then dir<=1
//   down, triangle : d'=(d<=step)?0:d-step; if d'==0 then dir<=0, cycle_done
//   sawtooth       : d==MAX -> d'=0, cycle_done; else d'=min(d+step,MAX); dir stays 0
//   single         : d==MAX -> DONE, cycle_done, no issue; else d'=min(d+step,MAX)
//  DONE: outputs held (duty=MAX, valid=0, busy=0); enable=0 -> IDLE.
//  Re-enable from IDLE resumes: reissues held duty with held dir. Duty restarts at 0 only after reset.
//  After ISSUE handshake with enable=0 -> IDLE instead of DWELL.
//  cycle_done is registered and high for exactly one clk.
// TESTING
//  1 triangle, step=64, dwell=3, ready=1: issued 0,64,128,192,255,191,127,63,0,64;
//    cycle_done with second 0; dir 1 from 255 until 0; valid low 3 clks between levels.
//  2 sawtooth, step=100, dwell=2: issued 0,100,200,255,0,100; cycle_done with the 0 after 255.
//  3 single, step=128, dwell=1: issued 0,128,255; then DONE: busy=0, valid=0, cycle_done 1 pulse;
//    enable=0 -> IDLE.
//  4 backpressure: ready=0 for 10 clks in ISSUE -> valid=1, duty constant;
//    enable dropped meanwhile; ready=1 -> one handshake, then IDLE, valid=0.
//  5 step=0, dwell=0 -> treated as 1: issued 0,1,2,3 with valid low exactly 1 clk between.
//  6 rst pulsed mid-DWELL and mid-ISSUE (between edges): duty=0, valid=0, busy=0, dir=0 immediately;
//    resumes at 0 after release.

Source files
------------

// File: rtl/pwm_duty_sequencer.sv
// Duty-cycle sequencer for a PWM core: steps the duty code through triangle, sawtooth
// or single-ramp patterns and issues each level over a valid/ready handshake.
module pwm_duty_sequencer #(
    parameter int unsigned DUTY_W   = 8,
    parameter int unsigned MAX_DUTY = 255,
    parameter int unsigned DWELL_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [1:0]         cfg_mode,
    input  logic [DUTY_W-1:0]  cfg_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    output logic [DUTY_W-1:0]  duty,
    output logic               duty_valid,
    input  logic               duty_ready,
    output logic               dir,
    output logic               busy,
    output logic               cycle_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DWELL = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0]        MODE_TRI  = 2'd0;
    localparam logic [1:0]        MODE_SAW  = 2'd1;
    localparam logic [1:0]        MODE_ONCE = 2'd2;
    localparam logic [DUTY_W-1:0] MAX_CODE  = DUTY_W'(MAX_DUTY);
    localparam logic [DUTY_W:0]   MAX_EXT   = (DUTY_W+1)'(MAX_DUTY);

    state_t               state_q, state_d;
    logic [DUTY_W-1:0]    duty_q, duty_d;
    logic                 dir_q, dir_d;
    logic                 valid_q, valid_d;
    logic                 busy_q, busy_d;
    logic                 cd_q, cd_d;
    logic [DWELL_W-1:0]   cnt_q, cnt_d;
    logic [1:0]           mode_q, mode_d;
    logic [DUTY_W-1:0]    step_q, step_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d;

    logic [DUTY_W:0]      sum;
    logic [DUTY_W-1:0]    up_lvl;
    logic [DUTY_W-1:0]    dn_lvl;

    // Saturating up/down candidates; the extra sum bit keeps d+step from wrapping.
    always_comb begin
        sum    = {1'b0, duty_q} + {1'b0, step_q};
        up_lvl = (sum >= MAX_EXT) ? MAX_CODE : sum[DUTY_W-1:0];
        dn_lvl = (duty_q <= step_q) ? '0 : duty_q - step_q;
    end

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        dir_d   = dir_q;
        cd_d    = 1'b0;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        step_d  = step_q;
        dwell_d = dwell_q;

        unique case (state_q)
            S_IDLE: begin
                if (enable) begin
                    mode_d  = (cfg_mode == 2'd3) ? MODE_TRI : cfg_mode;
                    step_d  = (cfg_step == '0) ? DUTY_W'(1) : cfg_step;
                    dwell_d = (cfg_dwell == '0) ? DWELL_W'(1) : cfg_dwell;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (duty_ready) begin
                    if (!enable) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DWELL;
                        cnt_d   = dwell_q - DWELL_W'(1);
                    end
                end
            end
            S_DWELL: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else begin
                    state_d = S_ISSUE;
                    unique case (mode_q)
                        MODE_SAW: begin
                            dir_d = 1'b0;
                            if (duty_q == MAX_CODE) begin
                                duty_d = '0;
                                cd_d   = 1'b1;
                            end else begin
                                duty_d = up_lvl;
                            end
                        end
                        MODE_ONCE: begin
                            if (duty_q == MAX_CODE) begin
                                state_d = S_DONE;
                                cd_d    = 1'b1;
                            end else begin
                                duty_d = up_lvl;
                            end
                        end
                        default: begin
                            if (!dir_q) begin
                                duty_d = up_lvl;
                                if (up_lvl == MAX_CODE) dir_d = 1'b1;
                            end else begin
                                duty_d = dn_lvl;
                                if (dn_lvl == '0) begin
                                    dir_d = 1'b0;
                                    cd_d  = 1'b1;
                                end
                            end
                        end
                    endcase
                end
            end
            S_DONE: begin
                if (!enable) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Status outputs are registered versions of the next state.
        valid_d = (state_d == S_ISSUE);
        busy_d  = (state_d == S_ISSUE) || (state_d == S_DWELL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            duty_q  <= '0;
            dir_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            cd_q    <= 1'b0;
            cnt_q   <= '0;
            mode_q  <= MODE_TRI;
            step_q  <= '0;
            dwell_q <= '0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            dir_q   <= dir_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            cd_q    <= cd_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            step_q  <= step_d;
            dwell_q <= dwell_d;
        end
    end

    assign duty       = duty_q;
    assign duty_valid = valid_q;
    assign dir        = dir_q;
    assign busy       = busy_q;
    assign cycle_done = cd_q;

endmodule
